// File: rtl/teclado_pkg.sv
// Shared definitions for the PS/2 keypad front end: scan bytes, key codes
// and the scan-sequence FSM state type.
package teclado_pkg;

    // Prefix bytes of the PS/2 scan set 2 protocol
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E0    = 8'hE0;

    // Make codes of the supported keys
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_N     = 8'h31;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_Q     = 8'h15;

    // Compact key codes; KC_NONE also means "no key held"
    localparam logic [3:0] KC_NONE  = 4'd0;
    localparam logic [3:0] KC_1     = 4'd1;
    localparam logic [3:0] KC_2     = 4'd2;
    localparam logic [3:0] KC_3     = 4'd3;
    localparam logic [3:0] KC_P     = 4'd4;
    localparam logic [3:0] KC_C     = 4'd5;
    localparam logic [3:0] KC_B     = 4'd6;
    localparam logic [3:0] KC_N     = 4'd7;
    localparam logic [3:0] KC_ENTER = 4'd8;
    localparam logic [3:0] KC_Q     = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

endpackage

// File: rtl/codificador_tecla.sv
// Combinational scan-byte to key-code encoder; unknown bytes map to KC_NONE.
module codificador_tecla
    import teclado_pkg::*;
(
    input  logic [7:0] scan,
    output logic [3:0] code
);

    // Table lookup of the nine supported make codes
    always_comb begin
        code = KC_NONE;
        case (scan)
            SC_1:     code = KC_1;
            SC_2:     code = KC_2;
            SC_3:     code = KC_3;
            SC_P:     code = KC_P;
            SC_C:     code = KC_C;
            SC_B:     code = KC_B;
            SC_N:     code = KC_N;
            SC_ENTER: code = KC_ENTER;
            SC_Q:     code = KC_Q;
            default:  code = KC_NONE;
        endcase
    end

endmodule

// File: rtl/teclado_control.sv
// PS/2 scan-sequence decoder: tracks F0/E0 prefixes, suppresses typematic
// repeats, keeps the currently held key and offers one event at a time to
// the consumer through a valid/ack handshake with a sticky overflow flag.
module teclado_control
    import teclado_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic       overflow,
    output logic [3:0] held_key
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       code;
    logic             timeout;
    logic             ev;
    logic             brk_clear;

    codificador_tecla u_codificador (
        .scan (rx_data),
        .code (code)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a byte arriving on the timeout cycle wins over the timeout
    always_comb begin
        state_next = state;
        if (rx_ready) begin
            case (state)
                IDLE: begin
                    if (rx_data == SC_F0)      state_next = BRK;
                    else if (rx_data == SC_E0) state_next = EXT;
                end
                EXT:     state_next = (rx_data == SC_F0) ? EXT_BRK : IDLE;
                BRK:     state_next = IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next = IDLE;
        end
    end

    // Decoded actions of the current cycle: key event, held-key release, timeout
    always_comb begin
        timeout   = (state != IDLE) && (cnt == CNT_LAST);
        ev        = rx_ready && (state == IDLE) && (rx_data != SC_F0) &&
                    (rx_data != SC_E0) && (code != KC_NONE) && (code != held_key);
        brk_clear = rx_ready && (state == BRK) && (code == held_key);
    end

    // Prefix timeout counter, held at zero in IDLE and restarted by every byte
    always_ff @(posedge clk) begin
        if (reset)                                   cnt <= '0;
        else if (rx_ready || state == IDLE || timeout) cnt <= '0;
        else                                         cnt <= cnt + 1'b1;
    end

    // Held key, event handshake and sticky overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            held_key  <= KC_NONE;
            key_valid <= 1'b0;
            key_code  <= KC_NONE;
            overflow  <= 1'b0;
        end else begin
            if (ev)             held_key <= code;
            else if (brk_clear) held_key <= KC_NONE;

            if (ev) begin
                if (!key_valid || key_ack) begin
                    key_code  <= code;
                    key_valid <= 1'b1;
                end else begin
                    overflow  <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_teclado_control.sv
// Directed bench for teclado_control with an expected-event scoreboard.
module tb_teclado_control;
    import teclado_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       key_ack = 1'b0;
    logic       key_valid;
    logic [3:0] key_code;
    logic       overflow;
    logic [3:0] held_key;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0]  exp_q[$];

    teclado_control #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .overflow  (overflow),
        .held_key  (held_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs driven at negedge, outputs sampled at the next negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic ack();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    task automatic check_event(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {7'd0, key_valid}, 8'd1);
            check({tag, "_code"}, {4'd0, key_code}, {4'd0, e});
        end
    endtask

    initial begin
        // Reset
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", {7'd0, key_valid}, 8'd0);
        check("rst_code", {4'd0, key_code}, 8'd0);
        check("rst_held", {4'd0, held_key}, 8'd0);
        check("rst_ovf", {7'd0, overflow}, 8'd0);

        // Press and release key 1
        exp_q.push_back(KC_1);
        send_byte(SC_1);
        check_event("k1");
        check("k1_held", {4'd0, held_key}, 8'd1);
        ack();
        check("k1_ack", {7'd0, key_valid}, 8'd0);
        ack();
        check("ack_idle_ignored", {7'd0, key_valid}, 8'd0);
        send_byte(SC_F0);
        check("k1_brk_held", {4'd0, held_key}, 8'd1);
        send_byte(SC_1);
        check("k1_rel_held", {4'd0, held_key}, 8'd0);
        check("k1_rel_noev", {7'd0, key_valid}, 8'd0);

        // Typematic Enter: one event only
        exp_q.push_back(KC_ENTER);
        send_byte(SC_ENTER);
        check_event("ent");
        ack();
        send_byte(SC_ENTER);
        check("ent_rep1", {7'd0, key_valid}, 8'd0);
        send_byte(SC_ENTER);
        check("ent_rep2", {7'd0, key_valid}, 8'd0);
        check("ent_held", {4'd0, held_key}, 8'd8);
        check("ent_ovf", {7'd0, overflow}, 8'd0);
        send_byte(SC_F0);
        send_byte(SC_ENTER);
        check("ent_rel", {4'd0, held_key}, 8'd0);

        // Overflow, then ack coinciding with a new make
        exp_q.push_back(KC_2);
        send_byte(SC_2);
        check_event("k2");
        send_byte(SC_3);
        check("ovf_code_kept", {4'd0, key_code}, 8'd2);
        check("ovf_set", {7'd0, overflow}, 8'd1);
        check("ovf_held", {4'd0, held_key}, 8'd3);
        exp_q.push_back(KC_Q);
        key_ack = 1'b1;
        send_byte(SC_Q);
        key_ack = 1'b0;
        check_event("q_ack_same");
        check("ovf_sticky", {7'd0, overflow}, 8'd1);
        ack();
        check("q_acked", {7'd0, key_valid}, 8'd0);

        // Extended sequences are discarded
        send_byte(SC_E0);
        send_byte(SC_ENTER);
        check("ext_noev", {7'd0, key_valid}, 8'd0);
        check("ext_held", {4'd0, held_key}, 8'd9);
        check("ext_state", {6'd0, dut.state}, {6'd0, IDLE});
        send_byte(SC_E0);
        send_byte(SC_F0);
        send_byte(SC_ENTER);
        check("extbrk_noev", {7'd0, key_valid}, 8'd0);
        check("extbrk_held", {4'd0, held_key}, 8'd9);
        check("extbrk_state", {6'd0, dut.state}, {6'd0, IDLE});
        send_byte(8'h00);
        check("invalid_noev", {7'd0, key_valid}, 8'd0);
        exp_q.push_back(KC_1);
        send_byte(SC_1);
        check_event("post_ext");
        ack();

        // Prefix timeout after 16 idle cycles
        send_byte(SC_F0);
        repeat (15) tick();
        check("to_still_brk", {6'd0, dut.state}, {6'd0, BRK});
        tick();
        check("to_idle", {6'd0, dut.state}, {6'd0, IDLE});
        check("to_noev", {7'd0, key_valid}, 8'd0);
        exp_q.push_back(KC_C);
        send_byte(SC_C);
        check_event("to_make");

        // Reset in BRK with an event pending; reset beats rx_ready and key_ack
        send_byte(SC_F0);
        check("pre_rst_valid", {7'd0, key_valid}, 8'd1);
        reset    = 1'b1;
        rx_ready = 1'b1;
        rx_data  = SC_1;
        key_ack  = 1'b1;
        tick();
        reset    = 1'b0;
        rx_ready = 1'b0;
        key_ack  = 1'b0;
        check("mid_rst_valid", {7'd0, key_valid}, 8'd0);
        check("mid_rst_code", {4'd0, key_code}, 8'd0);
        check("mid_rst_held", {4'd0, held_key}, 8'd0);
        check("mid_rst_ovf", {7'd0, overflow}, 8'd0);
        check("mid_rst_state", {6'd0, dut.state}, {6'd0, IDLE});
        exp_q.push_back(KC_B);
        send_byte(SC_B);
        check_event("after_rst");

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/teclado_control.md
TECLADO_CONTROL -- requirements
Module: teclado_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 50000; clock cycles allowed between a prefix byte (E0/F0) and its following byte.
REQ-002 The block SHALL have port clk, input, 1 bit; single clock for the block.
REQ-003 The block SHALL have port reset, input, 1 bit; synchronous, active-high reset (one clock, reset is synchronous and active-high).
REQ-004 The block SHALL have port rx_ready, input, 1 bit; one-cycle strobe: scan byte available from the PS/2 receiver.
REQ-005 The block SHALL have port rx_data, input, 8 bits; scan byte, sampled only when rx_ready=1.
REQ-006 The block SHALL have port key_valid, output, 1 bit; a key event is held in key_code.
REQ-007 The block SHALL have port key_code, output, 4 bits; encoded key (see REQ-012).
REQ-008 The block SHALL have port key_ack, input, 1 bit; consumer accepts the held event.
REQ-009 The block SHALL have port overflow, output, 1 bit; sticky flag: an event was dropped.
REQ-010 The block SHALL have port held_key, output, 4 bits; code of the key currently pressed, 0 = none.

Function
REQ-011 The FSM SHALL have states IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen).
REQ-012 Encoding SHALL be: 16->1, 1E->2, 26->3, 4D->4 (P), 21->5 (C), 32->6 (B), 31->7 (N), 5A->8 (Enter), 15->9 (Q); any other byte -> 0 (invalid).
REQ-013 In IDLE, rx_ready with byte F0 SHALL go to BRK, and E0 SHALL go to EXT; any other byte is a make code, and the FSM stays in IDLE.
REQ-014 In EXT, byte F0 SHALL go to EXT_BRK; any other byte SHALL be discarded with a return to IDLE (extended keys are not supported).
REQ-015 In BRK, the next byte SHALL return the FSM to IDLE; if its code equals held_key, held_key SHALL clear to 0.
REQ-016 In EXT_BRK, the next byte SHALL be discarded with a return to IDLE.
REQ-017 A make code with encoding 0 SHALL be ignored.
REQ-018 A make code whose encoding equals held_key (typematic repeat) SHALL NOT generate an event.
REQ-019 A valid make code that is not a repeat SHALL set held_key to its code and generate an event on the cycle after rx_ready.
REQ-020 Event while key_valid=0: key_code SHALL load the code and key_valid SHALL rise 1 cycle after rx_ready.
REQ-021 Event while key_valid=1 and key_ack=0: the event SHALL be dropped, overflow SHALL set, and key_code SHALL stay unchanged.
REQ-022 Event while key_valid=1 and key_ack=1 in the same cycle: the new code SHALL load and key_valid SHALL stay 1; there is no drop.
REQ-023 key_ack while key_valid=1 with no event SHALL clear key_valid on the next cycle; key_ack while key_valid=0 SHALL be ignored.
REQ-024 The timeout counter SHALL reset on every rx_ready and count while in BRK, EXT or EXT_BRK.
REQ-025 When the timeout counter reaches TIMEOUT_CYC-1, the FSM SHALL return to IDLE without generating an event.
REQ-026 The counter SHALL be sized ceil(log2(TIMEOUT_CYC)) bits and SHALL NOT wrap while in IDLE; it is held at 0 there.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On reset the block SHALL set: state=IDLE, key_valid=0, key_code=0, held_key=0, overflow=0, counter=0.
REQ-029 Reset SHALL take priority over rx_ready and key_ack in the same cycle.
REQ-030 Reset mid-sequence (e.g. in BRK) SHALL discard the partial sequence.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 The shared package teclado_pkg SHALL hold: the scan constants (F0, E0 and the nine key bytes), the 4-bit key code constants, and the FSM state enum.
REQ-033 The scan-to-code encoder SHALL be one combinational sub-module, codificador_tecla (rx_data -> 4-bit code).
REQ-034 The FSM, timeout counter, held-key register and output handshake SHALL live in teclado_control.

Verification
REQ-035 Bytes 16, F0, 16 with key_ack pulsed -> one event, key_code=1; held_key goes 1 then 0.
REQ-036 Bytes 5A, 5A, 5A (typematic), no break -> exactly one event, key_code=8.
REQ-037 Bytes 1E, then 26 with no key_ack -> key_code=2 retained, overflow=1; then key_ack with a simultaneous new make 15 -> key_code=9, key_valid stays 1.
REQ-038 Bytes E0, 5A and E0, F0, 5A -> no event, FSM back in IDLE, held_key unchanged.
REQ-039 TIMEOUT_CYC=16; byte F0, then idle 16 cycles, then byte 21 -> treated as a make, key_code=5.
REQ-040 Reset asserted while in BRK with key_valid=1 -> all outputs 0 next cycle; subsequent byte 32 -> key_code=6.
